// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID pipeline register.
//
// Owns the PC and fetches from instruction memory over a req/ack handshake. The stage
// registers the instruction and PC+4 for IF/ID, and keeps a one-entry skid buffer so an
// ack that lands while IF/ID is stalled is never lost. A taken branch flushes the output
// and the skid. If the branch hits while a request is still in flight, the stage enters
// SQUASH, which holds the stale request until memory acks it and then drops the data.
//
// Parameters:
//   RESET_PC      PC value after reset
//   NOP_INSTR     bubble instruction driven on RD_IF
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   stall                 IF/ID stall (1 = IF/ID holds)
//   branch_taken          single-cycle redirect request
//   branch_target         redirect address (bits [1:0] ignored)
//   imem_req/imem_addr    memory request; held stable until acked
//   imem_ack/imem_rdata   memory response
//   RD_IF, nextPC_IF      registered instruction and fetch address + 4
//   fetch_valid           1 = RD_IF is a real instruction, 0 = bubble
//   PC                    address of the next fetch
// Optional (macro IF_PERF_CNT_EN):
//   fetch_count           delivered (non-discarded) fetches
//   bubble_count          unstalled cycles that leave a bubble in the output register
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] RD_IF,
   output logic [31:0] nextPC_IF,
   output logic        fetch_valid,
`ifdef IF_PERF_CNT_EN
   output logic [31:0] fetch_count,
   output logic [31:0] bubble_count,
`endif
   output logic [31:0] PC
);

   typedef enum logic [0:0] {StFetch, StSquash} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] rd_q, rd_d;
   logic [31:0] npc_q, npc_d;
   logic        valid_q, valid_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc4_q, skid_pc4_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] squash_addr_q, squash_addr_d;
   // Low during the first cycle after reset so imem_req stays 0 while reset is active.
   logic        started_q;
   logic [31:0] pc_plus4;
   logic        ack_load;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      imem_req  = 1'b0;
      imem_addr = pc_q;
      if (state_q == StSquash) begin
         imem_req  = started_q;
         imem_addr = squash_addr_q;
      end else begin
         imem_req  = started_q & ~skid_valid_q;
      end
   end

   // An ack that actually delivers an instruction (not squashed, not hit by a branch).
   assign ack_load = (state_q == StFetch) && imem_req && imem_ack && !branch_taken;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      rd_d          = rd_q;
      npc_d         = npc_q;
      valid_d       = valid_q;
      skid_instr_d  = skid_instr_q;
      skid_pc4_d    = skid_pc4_q;
      skid_valid_d  = skid_valid_q;
      squash_addr_d = squash_addr_q;

      if (branch_taken) begin
         rd_d         = NOP_INSTR;
         valid_d      = 1'b0;
         skid_valid_d = 1'b0;
         pc_d         = branch_target & 32'hFFFF_FFFC;
         if (state_q == StFetch && imem_req && !imem_ack) begin
            // Request in flight: keep presenting it until memory answers, then drop data.
            state_d       = StSquash;
            squash_addr_d = pc_q;
         end else if (state_q == StSquash && imem_ack) begin
            state_d = StFetch;
         end
      end else begin
         if (state_q == StSquash && imem_ack) begin
            state_d = StFetch;
         end
         if (ack_load) begin
            pc_d = pc_plus4;
            if (!valid_q || !stall) begin
               rd_d    = imem_rdata;
               npc_d   = pc_plus4;
               valid_d = 1'b1;
            end else begin
               skid_instr_d = imem_rdata;
               skid_pc4_d   = pc_plus4;
               skid_valid_d = 1'b1;
            end
         end else if (!stall) begin
            if (skid_valid_q) begin
               rd_d         = skid_instr_q;
               npc_d        = skid_pc4_q;
               valid_d      = 1'b1;
               skid_valid_d = 1'b0;
            end else begin
               rd_d    = NOP_INSTR;
               valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StFetch;
         pc_q          <= RESET_PC;
         rd_q          <= NOP_INSTR;
         npc_q         <= 32'h0;
         valid_q       <= 1'b0;
         skid_instr_q  <= 32'h0;
         skid_pc4_q    <= 32'h0;
         skid_valid_q  <= 1'b0;
         squash_addr_q <= 32'h0;
         started_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         rd_q          <= rd_d;
         npc_q         <= npc_d;
         valid_q       <= valid_d;
         skid_instr_q  <= skid_instr_d;
         skid_pc4_q    <= skid_pc4_d;
         skid_valid_q  <= skid_valid_d;
         squash_addr_q <= squash_addr_d;
         started_q     <= 1'b1;
      end
   end

   assign RD_IF       = rd_q;
   assign nextPC_IF   = npc_q;
   assign fetch_valid = valid_q;
   assign PC          = pc_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, bubble_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_cnt_q  <= 32'h0;
         bubble_cnt_q <= 32'h0;
      end else begin
         if (ack_load) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (!stall && !valid_d) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
         end
      end
   end

   assign fetch_count  = fetch_cnt_q;
   assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that produces the IF-side inputs of the IF/ID pipeline register: `RD_IF` (instruction) and `nextPC_IF` (PC+4).
- Owns the PC and talks to instruction memory through a req/ack handshake.
- Honours the same `stall` that freezes IF/ID and redirects on `branch_taken`.
- Inserts NOP bubbles whenever no valid instruction is ready, so IF/ID never captures a duplicate or stale instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0000, bubble instruction driven on `RD_IF`.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  same signal as IF/ID stall; 1 = IF/ID holds its contents.
- branch_taken  input  1  single-cycle redirect request.
- branch_target  input  32  redirect address; bits [1:0] are forced to 0.
- imem_req  output  1  instruction memory request.
- imem_addr  output  32  request address; stable while `imem_req`=1 and no ack.
- imem_ack  input  1  memory has returned `imem_rdata` this cycle.
- imem_rdata  input  32  instruction word, valid when `imem_ack`=1.
- RD_IF  output  32  registered instruction to IF/ID.
- nextPC_IF  output  32  registered fetch address + 4, to IF/ID.
- fetch_valid  output  1  1 = `RD_IF` holds a real instruction, 0 = bubble.
- PC  output  32  address of the next fetch.

Behaviour:
- Reset (async, `reset`=0):
  - PC = RESET_PC; `RD_IF` = NOP_INSTR; `nextPC_IF` = 0; `fetch_valid` = 0.
  - Skid buffer empty; state = FETCH; `imem_req` = 0.
  - Reset mid-request abandons the request. Memory must drop it too.
- Storage: output register (`RD_IF`, `nextPC_IF`, `fetch_valid`) plus a one-entry skid buffer (instr, pc4, `skid_valid`).
- States:
  - FETCH: `imem_addr` = PC; `imem_req` = !`skid_valid`.
  - SQUASH: `imem_addr` = latched stale address; `imem_req` = 1.
- Handshake:
  - Once `imem_req` rises without `imem_ack`, both `imem_req` and `imem_addr` hold until ack, regardless of `stall`.
  - Zero-wait ack (same cycle as req) is legal.
- Accepted ack in FETCH (no branch that cycle):
  - PC <= PC+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - If `fetch_valid`=0 or `stall`=0: output reg <= {`imem_rdata`, PC+4, valid=1}.
  - Otherwise: skid <= {`imem_rdata`, PC+4}, `skid_valid`=1.
- `stall`=0 with no ack load this cycle:
  - If `skid_valid`: output reg <= skid and `skid_valid` <= 0.
  - Else: output reg <= {NOP_INSTR, unchanged `nextPC_IF`, valid=0}.
- `stall`=1 with no ack load: output reg and skid hold.
- Full-throughput case: `stall`=0 with zero-wait memory delivers one instruction per cycle.
- `branch_taken`=1 has highest priority, over both `stall` and ack:
  - Output reg <= NOP (valid=0); skid cleared; PC <= {`branch_target`[31:2], 2'b00}.
  - If a request is outstanding with no ack this cycle, go to SQUASH and latch the stale address.
  - If ack arrives in the same cycle, discard the data and stay in FETCH.
- SQUASH:
  - On ack, discard the data, go to FETCH; new requests resume next cycle.
  - `branch_taken` in SQUASH updates PC only and stays in SQUASH.
- No instruction is ever lost or duplicated across stall/branch combinations.

Optional Feature:
- Macro `IF_PERF_CNT_EN`.
- Defined:
  - Adds outputs `fetch_count` [31:0] and `bubble_count` [31:0], both 0 on reset, wrap at 2^32.
  - `fetch_count` increments on each accepted, non-discarded ack.
  - `bubble_count` increments on each posedge with `stall`=0 and `fetch_valid`=0 after update.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert `reset`=0 mid-request with RESET_PC=32'h100 -> `RD_IF`=0, `nextPC_IF`=0, `fetch_valid`=0, `imem_req`=0, PC=32'h100. After release, first `imem_addr`=32'h100.
- Streaming: zero-wait memory returns addr^32'hA5A5_0000, `stall`=0 -> consecutive `RD_IF` for addresses 0,4,8,…, `nextPC_IF`=4,8,12,…, one per cycle, `fetch_valid`=1 throughout.
- Stall/skid: `stall`=1 for 3 cycles while an ack arrives -> `RD_IF` holds, skid fills, `imem_req`=0. After `stall` falls, the skid instruction appears next cycle with no gap or duplicate.
- Branch squash: 3-cycle memory latency, `branch_taken` with `branch_target`=32'h43 during an outstanding request to 32'h10 -> data for 32'h10 discarded, `RD_IF`=NOP. Next request `imem_addr`=32'h40, then `nextPC_IF`=32'h44.
- Branch+stall+ack same cycle -> output NOP, skid empty, PC=target, ack data discarded.
- Wrap: PC=32'hFFFF_FFFC fetched -> `nextPC_IF`=0, next `imem_addr`=0. With `IF_PERF_CNT_EN`, the counters match expected totals.
